stream_handshake_monitor: RTL and testbench

// - Passive tap on a valid/ready stream, e.g. between a random stream master and a random stream slave.
// - Counts handshakes, measures stall lengths and flags protocol violations.
// - Drives no stream signal; results feed bench checks and end-of-test reports.

---
 rtl/stream_handshake_monitor.sv | 150 +++++++++++++++
 tb/tb_stream_handshake_monitor.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_handshake_monitor.sv
// Passive valid/ready stream monitor: counts handshakes, tracks the longest stall and raises sticky protocol-error flags.
// Optional build macro STREAM_MON_ASSERT_EN adds simulation-only $error messages on flag set and on X/Z handshake inputs.
module stream_handshake_monitor #(
    parameter type         data_t     = logic,
    parameter int unsigned CntWidth   = 32,
    parameter int unsigned StallLimit = 1000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                clr_i,
    input  logic                valid_i,
    input  logic                ready_i,
    input  data_t               data_i,
    output logic [CntWidth-1:0] hs_cnt_o,
    output logic [CntWidth-1:0] max_stall_o,
    output logic                err_valid_drop_o,
    output logic                err_data_change_o,
    output logic                err_stall_o
);

    localparam logic [0:0]          ST_IDLE    = 1'b0;
    localparam logic [0:0]          ST_PENDING = 1'b1;
    localparam logic [CntWidth-1:0] CNT_MAX    = '1;

    logic [0:0]          r_state, w_state_nxt;
    logic [CntWidth-1:0] r_stall_cnt, w_stall_cnt_nxt;
    logic [CntWidth-1:0] r_hs_cnt, w_hs_cnt_nxt;
    logic [CntWidth-1:0] r_max_stall, w_max_stall_nxt;
    data_t               r_snap, w_snap_nxt;
    logic                r_err_drop, w_err_drop_nxt;
    logic                r_err_dchg, w_err_dchg_nxt;
    logic                r_err_stall, w_err_stall_nxt;

    logic                w_valid, w_ready, w_hit_limit;
    logic [CntWidth-1:0] w_stall_inc, w_hs_inc, w_max_upd;

    // Unknown handshake inputs count as deasserted
    assign w_valid = (valid_i === 1'b1);
    assign w_ready = (ready_i === 1'b1);

    assign w_stall_inc = (r_stall_cnt == CNT_MAX) ? r_stall_cnt : r_stall_cnt + CntWidth'(1);
    assign w_hs_inc    = (r_hs_cnt == CNT_MAX) ? r_hs_cnt : r_hs_cnt + CntWidth'(1);
    assign w_max_upd   = (r_stall_cnt > r_max_stall) ? r_stall_cnt : r_max_stall;
    // Compared in 64 bits so a limit beyond the counter range simply never fires
    assign w_hit_limit = (StallLimit != 0) &&
                         ((64'(r_stall_cnt) + 64'd1) == 64'(StallLimit));

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_stall_cnt_nxt = r_stall_cnt;
        w_hs_cnt_nxt    = r_hs_cnt;
        w_max_stall_nxt = r_max_stall;
        w_snap_nxt      = r_snap;
        w_err_drop_nxt  = r_err_drop;
        w_err_dchg_nxt  = r_err_dchg;
        w_err_stall_nxt = r_err_stall;
        if (clr_i) begin
            w_state_nxt     = ST_IDLE;
            w_stall_cnt_nxt = '0;
            w_hs_cnt_nxt    = '0;
            w_max_stall_nxt = '0;
            w_snap_nxt      = '0;
            w_err_drop_nxt  = 1'b0;
            w_err_dchg_nxt  = 1'b0;
            w_err_stall_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid && w_ready) begin
                        w_hs_cnt_nxt = w_hs_inc;
                    end else if (w_valid) begin
                        w_snap_nxt      = data_i;
                        w_stall_cnt_nxt = CntWidth'(1);
                        w_state_nxt     = ST_PENDING;
                        if (w_hit_limit) w_err_stall_nxt = 1'b1;
                    end
                end
                ST_PENDING: begin
                    if (!w_valid) begin
                        w_err_drop_nxt  = 1'b1;
                        w_max_stall_nxt = w_max_upd;
                        w_stall_cnt_nxt = '0;
                        w_state_nxt     = ST_IDLE;
                    end else begin
                        // Snapshot is kept so every later deviation re-flags
                        if (data_i != r_snap) w_err_dchg_nxt = 1'b1;
                        if (w_ready) begin
                            w_hs_cnt_nxt    = w_hs_inc;
                            w_max_stall_nxt = w_max_upd;
                            w_stall_cnt_nxt = '0;
                            w_state_nxt     = ST_IDLE;
                        end else begin
                            w_stall_cnt_nxt = w_stall_inc;
                            if (w_hit_limit) w_err_stall_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= '0;
            r_hs_cnt    <= '0;
            r_max_stall <= '0;
            r_snap      <= '0;
            r_err_drop  <= 1'b0;
            r_err_dchg  <= 1'b0;
            r_err_stall <= 1'b0;
        end else begin
            r_stall_cnt <= w_stall_cnt_nxt;
            r_hs_cnt    <= w_hs_cnt_nxt;
            r_max_stall <= w_max_stall_nxt;
            r_snap      <= w_snap_nxt;
            r_err_drop  <= w_err_drop_nxt;
            r_err_dchg  <= w_err_dchg_nxt;
            r_err_stall <= w_err_stall_nxt;
        end
    end

    assign hs_cnt_o          = r_hs_cnt;
    assign max_stall_o       = r_max_stall;
    assign err_valid_drop_o  = r_err_drop;
    assign err_data_change_o = r_err_dchg;
    assign err_stall_o       = r_err_stall;

`ifdef STREAM_MON_ASSERT_EN
    always @(posedge clk_i) begin
        if (rst_ni) begin
            if ($isunknown(valid_i) || $isunknown(ready_i))
                $error("stream_handshake_monitor: valid_i/ready_i unknown at %0t", $time);
            if (w_err_drop_nxt && !r_err_drop)
                $error("stream_handshake_monitor: err_valid_drop_o set at %0t", $time);
            if (w_err_dchg_nxt && !r_err_dchg)
                $error("stream_handshake_monitor: err_data_change_o set at %0t", $time);
            if (w_err_stall_nxt && !r_err_stall)
                $error("stream_handshake_monitor: err_stall_o set at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_stream_handshake_monitor.sv
// Bench for stream_handshake_monitor: three parameterisations share one stimulus stream and
// are checked every cycle against an event-level reference model, plus directed constant checks.
module tb_stream_handshake_monitor;

    logic       clk = 1'b0;
    logic       rst_n, clr, v, r;
    logic [7:0] d;

    always #5 clk = ~clk;

    // Config 0: 32-bit, limit 3; config 1: 32-bit, limit disabled; config 2: 2-bit, limit 2
    logic [31:0] a_hs, a_max, b_hs, b_max;
    logic [1:0]  c_hs, c_max;
    logic        a_drop, a_dchg, a_stl, b_drop, b_dchg, b_stl, c_drop, c_dchg, c_stl;

    stream_handshake_monitor #(.data_t(logic [7:0]), .CntWidth(32), .StallLimit(3)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(v), .ready_i(r), .data_i(d),
        .hs_cnt_o(a_hs), .max_stall_o(a_max), .err_valid_drop_o(a_drop),
        .err_data_change_o(a_dchg), .err_stall_o(a_stl));
    stream_handshake_monitor #(.data_t(logic [7:0]), .CntWidth(32), .StallLimit(0)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(v), .ready_i(r), .data_i(d),
        .hs_cnt_o(b_hs), .max_stall_o(b_max), .err_valid_drop_o(b_drop),
        .err_data_change_o(b_dchg), .err_stall_o(b_stl));
    stream_handshake_monitor #(.data_t(logic [7:0]), .CntWidth(2), .StallLimit(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .valid_i(v), .ready_i(r), .data_i(d),
        .hs_cnt_o(c_hs), .max_stall_o(c_max), .err_valid_drop_o(c_drop),
        .err_data_change_o(c_dchg), .err_stall_o(c_stl));

    int n_tests = 0;
    int n_fail  = 0;

    longint unsigned m_hs[3], m_max[3], m_len[3];
    logic            m_drop[3], m_dchg[3], m_stl[3];
    logic [7:0]      m_snap[3];

    function automatic longint unsigned lim(int k);
        return (k == 0) ? 64'd3 : (k == 1) ? 64'd0 : 64'd2;
    endfunction

    function automatic longint unsigned cmax(int k);
        return (k == 2) ? 64'd3 : 64'hFFFF_FFFF;
    endfunction

    function automatic longint unsigned sat(longint unsigned x, int k);
        return (x > cmax(k)) ? cmax(k) : x;
    endfunction

    function automatic longint unsigned mx(longint unsigned x, longint unsigned y);
        return (x > y) ? x : y;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_hs[k] = 0; m_max[k] = 0; m_len[k] = 0;
            m_drop[k] = 1'b0; m_dchg[k] = 1'b0; m_stl[k] = 1'b0; m_snap[k] = 8'h00;
        end
    endfunction

    // m_len is the running length of the current stall (0 = no transfer pending), unbounded
    function automatic void model_step(logic cl, logic vi, logic ri, logic [7:0] di);
        logic vv, rr;
        vv = (vi === 1'b1);
        rr = (ri === 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (cl) begin
                m_hs[k] = 0; m_max[k] = 0; m_len[k] = 0;
                m_drop[k] = 1'b0; m_dchg[k] = 1'b0; m_stl[k] = 1'b0; m_snap[k] = 8'h00;
            end else if (m_len[k] != 0) begin
                if (!vv) begin
                    m_drop[k] = 1'b1;
                    m_max[k]  = mx(m_max[k], sat(m_len[k], k));
                    m_len[k]  = 0;
                end else begin
                    if (di != m_snap[k]) m_dchg[k] = 1'b1;
                    if (rr) begin
                        m_hs[k]  = sat(m_hs[k] + 1, k);
                        m_max[k] = mx(m_max[k], sat(m_len[k], k));
                        m_len[k] = 0;
                    end else begin
                        if (lim(k) != 0 && sat(m_len[k], k) + 1 == lim(k)) m_stl[k] = 1'b1;
                        m_len[k] = m_len[k] + 1;
                    end
                end
            end else if (vv && rr) begin
                m_hs[k] = sat(m_hs[k] + 1, k);
            end else if (vv) begin
                m_snap[k] = di;
                if (lim(k) == 1) m_stl[k] = 1'b1;
                m_len[k] = 1;
            end
        end
    endfunction

    task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("a_hs", 64'(a_hs), m_hs[0]);     chk("a_max", 64'(a_max), m_max[0]);
        chk("a_drop", 64'(a_drop), 64'(m_drop[0])); chk("a_dchg", 64'(a_dchg), 64'(m_dchg[0]));
        chk("a_stall", 64'(a_stl), 64'(m_stl[0]));
        chk("b_hs", 64'(b_hs), m_hs[1]);     chk("b_max", 64'(b_max), m_max[1]);
        chk("b_drop", 64'(b_drop), 64'(m_drop[1])); chk("b_dchg", 64'(b_dchg), 64'(m_dchg[1]));
        chk("b_stall", 64'(b_stl), 64'(m_stl[1]));
        chk("c_hs", 64'(c_hs), m_hs[2]);     chk("c_max", 64'(c_max), m_max[2]);
        chk("c_drop", 64'(c_drop), 64'(m_drop[2])); chk("c_dchg", 64'(c_dchg), 64'(m_dchg[2]));
        chk("c_stall", 64'(c_stl), 64'(m_stl[2]));
    endtask

    task automatic cyc(input logic cl, input logic vi, input logic ri, input logic [7:0] di);
        clr = cl; v = vi; r = ri; d = di;
        @(posedge clk);
        model_step(cl, vi, ri, di);
        #1;
        check_all();
    endtask

    task automatic do_clr();
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; v = 1'b0; r = 1'b0; d = 8'h00;
        model_reset();
        #12;
        check_all();
        @(negedge clk) rst_n = 1'b1;

        // Back-to-back handshakes
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b1, 8'(i));
        chk("t1_hs", 64'(a_hs), 5); chk("t1_max", 64'(a_max), 0); chk("t1_c_sat", 64'(c_hs), 3);

        // Four-cycle stall with stable data
        do_clr();
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 8'h3C);
        cyc(1'b0, 1'b1, 1'b1, 8'h3C);
        chk("t2_hs", 64'(a_hs), 1); chk("t2_max", 64'(a_max), 4); chk("t2_dchg", 64'(a_dchg), 0);

        // Data change while stalled is sticky until clear
        do_clr();
        cyc(1'b0, 1'b1, 1'b0, 8'hA5);
        chk("t3_pre", 64'(a_dchg), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h5A);
        chk("t3_set", 64'(a_dchg), 1);
        cyc(1'b0, 1'b1, 1'b1, 8'h5A);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("t3_sticky", 64'(a_dchg), 1);
        do_clr();
        chk("t3_clr", 64'(a_dchg), 0);

        // Valid dropped before handshake
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        cyc(1'b0, 1'b1, 1'b0, 8'h11);
        cyc(1'b0, 1'b0, 1'b0, 8'h11);
        chk("t4_drop", 64'(a_drop), 1); chk("t4_hs", 64'(a_hs), 0); chk("t4_max", 64'(a_max), 2);

        // Stall limit: flag on the third consecutive stall cycle for limit 3
        do_clr();
        cyc(1'b0, 1'b1, 1'b0, 8'h22);
        cyc(1'b0, 1'b1, 1'b0, 8'h22);
        chk("t5_not_yet", 64'(a_stl), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h22);
        chk("t5_set", 64'(a_stl), 1);

        // Long stall: disabled limit never fires, 2-bit max saturates
        do_clr();
        for (int i = 0; i < 2000; i++) cyc(1'b0, 1'b1, 1'b0, 8'h77);
        cyc(1'b0, 1'b1, 1'b1, 8'h77);
        chk("t6_b_stall", 64'(b_stl), 0); chk("t6_a_max", 64'(a_max), 2000);
        chk("t6_c_max", 64'(c_max), 3);

        // Saturation, clear, then async reset mid-stall
        do_clr();
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 8'h00);
        chk("t7_c_hs", 64'(c_hs), 3); chk("t7_a_hs", 64'(a_hs), 6);
        do_clr();
        chk("t7_clr_hs", 64'(a_hs), 0);
        cyc(1'b0, 1'b1, 1'b0, 8'h44);
        cyc(1'b0, 1'b1, 1'b0, 8'h44);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t7_rst_c_max", 64'(c_max), 0);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h44);
        chk("t7_no_drop", 64'(a_drop), 0);

        // Unknown valid counts as not valid
        cyc(1'b0, 1'bx, 1'b1, 8'h10);
        cyc(1'b0, 1'b1, 1'b0, 8'h10);
        cyc(1'b0, 1'bx, 1'b0, 8'h10);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic       rc, rv, rr;
            logic [7:0] rd;
            rc = ($urandom_range(0, 63) == 0);
            rv = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) == 0);
            rd = ($urandom_range(0, 9) == 0) ? 8'($urandom) : d;
            cyc(rc, rv, rr, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
